// File: rtl/sm_keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sm_keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_t;

  // One full-scan result. The none flag marks a scan with every row
  // reading idle; code is then meaningless.
  typedef struct packed {
    logic       none;
    logic [3:0] code;
  } scan_res_t;

  localparam scan_res_t RES_NONE = '{none: 1'b1, code: 4'h0};

  // Index of the lowest-numbered low (pressed) column.
  // The caller must first check that at least one column is low.
  function automatic logic [1:0] first_low_col(input logic [COLS-1:0] col_n);
    logic [1:0] c;
    c = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) c = i[1:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/sm_sync2.sv
// Generic 2-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles.
// Backpressure: none; it samples on every cycle.
// Ports: clk, rst_n (async active-low); d = async input; q = synchronized output.
module sm_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sm_keypad_scan.sv
// 4x4 matrix keypad scanner. It drives the rows, samples the columns, debounces
// whole scans, and reports a stable key code.
// Latency: 2 (sync) + up to 1 partial scan + DEBOUNCE_SCANS full scans to key_valid.
// Backpressure: none. Scanning runs freely and key_valid is a single-cycle strobe.
// Ports: clk, rst_n (async active-low); row_n = active-low row drive;
//   col_n = async active-low column sense; key_code = {row,col} of the last accepted key;
//   key_valid = new-press strobe; key_held = the accepted key is still pressed.
module sm_keypad_scan
  import sm_keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0]  col_s;
  logic [15:0] slot_cnt;
  logic [1:0]  row;
  scan_res_t   acc;
  scan_res_t   sample_res;
  logic        slot_last;
  logic        scan_end;

  kp_state_t   state, state_nx;
  logic [3:0]  cand, cand_nx;
  logic [3:0]  dcnt, dcnt_nx;
  logic [3:0]  dcnt_inc;
  logic [3:0]  code_nx;
  logic        valid_nx;
  logic        held_nx;

  sm_sync2 #(.WIDTH(4), .RESET_VAL(4'b1111)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  assign slot_last = (slot_cnt == SCAN_DIV - 16'd1);
  assign scan_end  = slot_last && (row == 2'd3);
  assign row_n     = ~(4'b0001 << row);

  // The accumulator keeps the first hit of the scan, so lower rows win over
  // higher rows. It also folds in the current row's sample. At scan end this
  // gives the complete result, including row 3.
  always_comb begin
    sample_res = acc;
    if (acc.none && (col_s != 4'b1111)) begin
      sample_res = '{none: 1'b0, code: {row, first_low_col(col_s)}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= 16'd0;
      row      <= 2'd0;
      acc      <= RES_NONE;
    end else begin
      if (slot_last) begin
        slot_cnt <= 16'd0;
        row      <= row + 2'd1;
        acc      <= scan_end ? RES_NONE : sample_res;
      end else begin
        slot_cnt <= slot_cnt + 16'd1;
      end
    end
  end

  assign dcnt_inc = dcnt + 4'd1;

  // The debounce FSM advances only at scan end. At every other cycle it holds its
  // state, and the strobe stays low.
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    dcnt_nx  = dcnt;
    code_nx  = key_code;
    valid_nx = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (!sample_res.none) begin
            cand_nx = sample_res.code;
            dcnt_nx = 4'd1;
            if (DEBOUNCE_SCANS == 4'd1) begin
              code_nx  = sample_res.code;
              valid_nx = 1'b1;
              state_nx = HELD;
            end else begin
              state_nx = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (sample_res.none) begin
            state_nx = IDLE;
          end else if (sample_res.code == cand) begin
            dcnt_nx = dcnt_inc;
            if (dcnt_inc == DEBOUNCE_SCANS) begin
              code_nx  = cand;
              valid_nx = 1'b1;
              state_nx = HELD;
            end
          end else begin
            cand_nx = sample_res.code;
            dcnt_nx = 4'd1;
          end
        end
        HELD: begin
          // Any key here, including a different one, keeps the FSM in HELD.
          // A new key is reported only after a full release.
          if (sample_res.none) begin
            dcnt_nx  = 4'd1;
            state_nx = (DEBOUNCE_SCANS == 4'd1) ? IDLE : REL_DB;
          end
        end
        REL_DB: begin
          if (sample_res.none) begin
            dcnt_nx = dcnt_inc;
            if (dcnt_inc == DEBOUNCE_SCANS) state_nx = IDLE;
          end else begin
            state_nx = HELD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign held_nx = (state_nx == HELD) || (state_nx == REL_DB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'd0;
      dcnt      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      dcnt      <= dcnt_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

endmodule

// File: tb/tb_sm_keypad_scan.sv
module tb_sm_keypad_scan;

  localparam int SCAN = 16;             // 4 rows x SCAN_DIV(4)
  localparam int LAT  = 2 + SCAN + 3 * SCAN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = 16'h0000;         // bit r*4+c = key (r,c) pressed
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        prev_valid = 1'b0;

  sm_keypad_scan #(.SCAN_DIV(16'd4), .DEBOUNCE_SCANS(4'd3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its driven-low row onto its column.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // One clock step. Outputs are sampled 1 ns after the rising edge,
  // and every key_valid strobe is matched against the scoreboard.
  task automatic tick();
    logic [3:0] exp;
    @(posedge clk);
    #1;
    if (rst_n && key_valid) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse key_code=%h required=no pulse", key_code);
      end else begin
        exp = exp_q.pop_front();
        if (key_code !== exp) begin
          errors++;
          $display("FAIL pulse_code key_code=%h required=%h", key_code, exp);
        end
      end
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL double_pulse key_valid=1 on consecutive cycles required=single");
      end
      checks++;
      if (key_held !== 1'b1) begin
        errors++;
        $display("FAIL held_at_pulse key_held=%b required=1", key_held);
      end
    end
    prev_valid = key_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulse(input int budget, output int waited, output bit seen);
    int start;
    start  = pulse_cnt;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (pulse_cnt != start) seen = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output int waited, output bit seen);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (key_held === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst_n = 1'b0;
    ticks(10);
    checks++;
    if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n row_n=%b required=1110", row_n); end
    checks++;
    if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code key_code=%h required=0", key_code); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid key_valid=%b required=0", key_valid); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held key_held=%b required=0", key_held); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_row = ~(4'b0001 << (((i + 1) / 4) % 4));
      checks++;
      if (row_n !== exp_row) begin
        errors++;
        $display("FAIL row_sequence cycle=%0d row_n=%b required=%b", i + 1, row_n, exp_row);
      end
    end
  endtask

  task automatic test_stable_press();
    int  waited;
    bit  seen;
    int  pc;
    keys = 16'h0200;                    // key (2,1)
    exp_q.push_back(4'h9);
    wait_pulse(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL press_timeout waited=%0d required<=%0d", waited, LAT); end
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL press_held key_held=%b required=1", key_held); end
    pc = pulse_cnt;
    ticks(20 * SCAN);
    checks++;
    if (pulse_cnt != pc) begin errors++; $display("FAIL press_hold_repeat pulses=%0d required=%0d", pulse_cnt, pc); end
    checks++;
    if (key_code !== 4'h9) begin errors++; $display("FAIL press_hold_code key_code=%h required=9", key_code); end
  endtask

  task automatic test_release();
    int waited;
    bit seen;
    keys = 16'h0000;
    wait_release(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL release_timeout waited=%0d required<=%0d", waited, LAT); end
    // Three NONE scan ends are needed, so the release takes at least two full scans.
    checks++;
    if (waited < 2 * SCAN) begin errors++; $display("FAIL release_too_early waited=%0d required>=%0d", waited, 2 * SCAN); end
    checks++;
    if (key_code !== 4'h9) begin errors++; $display("FAIL release_code key_code=%h required=9", key_code); end
  endtask

  task automatic test_bounce();
    int waited;
    bit seen;
    int pc;
    pc = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;   // key (0,3)
      ticks(SCAN);
    end
    checks++;
    if (pulse_cnt != pc) begin errors++; $display("FAIL bounce_pulse pulses=%0d required=%0d", pulse_cnt, pc); end
    keys = 16'h0008;
    exp_q.push_back(4'h3);
    wait_pulse(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bounce_stable_timeout waited=%0d required<=%0d", waited, LAT); end
    keys = 16'h0000;
    wait_release(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bounce_release_timeout waited=%0d required<=%0d", waited, LAT); end
  endtask

  task automatic test_two_keys();
    int waited;
    bit seen;
    int pc;
    keys = 16'h1040;                    // (1,2) and (3,0)
    exp_q.push_back(4'h6);
    wait_pulse(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL two_keys_timeout waited=%0d required<=%0d", waited, LAT); end
    pc = pulse_cnt;
    keys = 16'h1041;                    // add (0,0) while held
    ticks(10 * SCAN);
    checks++;
    if (pulse_cnt != pc) begin errors++; $display("FAIL rollover_pulse pulses=%0d required=%0d", pulse_cnt, pc); end
    checks++;
    if (key_code !== 4'h6) begin errors++; $display("FAIL rollover_code key_code=%h required=6", key_code); end
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL rollover_held key_held=%b required=1", key_held); end
    keys = 16'h0000;
    wait_release(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL two_keys_release_timeout waited=%0d required<=%0d", waited, LAT); end
  endtask

  task automatic test_reset_mid_debounce();
    int waited;
    bit seen;
    keys = 16'h0020;                    // key (1,1)
    ticks(30);                          // inside PRESS_DB, before any accept is possible
    rst_n = 1'b0;
    ticks(5);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid key_valid=%b required=0", key_valid); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held key_held=%b required=0", key_held); end
    checks++;
    if (key_code !== 4'h0) begin errors++; $display("FAIL midrst_code key_code=%h required=0", key_code); end
    checks++;
    if (row_n !== 4'b1110) begin errors++; $display("FAIL midrst_row_n row_n=%b required=1110", row_n); end
    rst_n = 1'b1;
    exp_q.push_back(4'h5);
    wait_pulse(LAT, waited, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_timeout waited=%0d required<=%0d", waited, LAT); end
    // With a fresh debounce from IDLE, the accept needs three full scan ends.
    checks++;
    if (waited < 2 * SCAN + 8) begin errors++; $display("FAIL midrst_early waited=%0d required>=%0d", waited, 2 * SCAN + 8); end
    keys = 16'h0000;
    ticks(5 * SCAN);
  endtask

  initial begin
    test_reset();
    test_stable_press();
    test_release();
    test_bounce();
    test_two_keys();
    test_reset_mid_debounce();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover pending=%0d required=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
